// File: rtl/vga_pattern_gen_if.sv
// External pixel stream handshake between a pixel source and the pattern generator.
interface vga_pattern_gen_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  // Pixel source side (e.g. frame-buffer FIFO)
  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  // Generator side
  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA/LCD timing generator with grid, colour-bar, solid and external-stream pixel sources.
// All video outputs are registered and reflect the counter state of the previous cycle.
module vga_pattern_gen #(
  parameter int unsigned HDISP         = 800,
  parameter int unsigned VDISP         = 480,
  parameter int unsigned HFP           = 40,
  parameter int unsigned HPULSE        = 48,
  parameter int unsigned HBP           = 40,
  parameter int unsigned VFP           = 13,
  parameter int unsigned VPULSE        = 3,
  parameter int unsigned VBP           = 29,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int unsigned GRID_LOG2     = 4,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF,
  localparam int unsigned XW           = $clog2(HDISP),
  localparam int unsigned YW           = $clog2(VDISP)
) (
  input  logic                pixel_clk,
  input  logic                pixel_rst,
  input  logic [1:0]          mode,
  input  logic [23:0]         solid_rgb,
  vga_pattern_gen_if.slave    pix,
  input  logic                clr_underflow,
  output logic                video_clk,
  output logic                video_hs,
  output logic                video_vs,
  output logic                video_blank,
  output logic [23:0]         video_rgb,
  output logic [XW-1:0]       x_pos,
  output logic [YW-1:0]       y_pos,
  output logic                frame_start,
  output logic                underflow
);

  localparam int unsigned HAS   = HFP + HPULSE + HBP;
  localparam int unsigned VAS   = VFP + VPULSE + VBP;
  localparam int unsigned HTOT  = HAS + HDISP;
  localparam int unsigned VTOT  = VAS + VDISP;
  localparam int unsigned HW    = $clog2(HTOT);
  localparam int unsigned VW    = $clog2(VTOT);
  localparam int unsigned BAR_W = HDISP / 8;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    mode_q;

  logic          end_line;
  logic          end_frame;
  logic          active;
  logic          hs_sync;
  logic          vs_sync;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;
  logic          grid_on;
  logic [2:0]    bar_idx;
  logic [23:0]   rgb_c;
  logic          starve;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  assign video_clk = pixel_clk;

  assign end_line  = (hcnt == HW'(HTOT - 1));
  assign end_frame = end_line && (vcnt == VW'(VTOT - 1));
  assign active    = (hcnt >= HW'(HAS)) && (vcnt >= VW'(VAS));
  assign hs_sync   = (hcnt >= HW'(HFP)) && (hcnt < HW'(HFP + HPULSE));
  assign vs_sync   = (vcnt >= VW'(VFP)) && (vcnt < VW'(VFP + VPULSE));
  assign x_c       = XW'(hcnt - HW'(HAS));
  assign y_c       = YW'(vcnt - VW'(VAS));
  assign grid_on   = (&x_c[GRID_LOG2-1:0]) || (&y_c[GRID_LOG2-1:0]);

  // Stream handshake is driven straight from the counters so the source sees it in the consuming cycle
  assign pix.pix_ready = (mode_q == 2'd3) && active;
  assign starve        = pix.pix_ready && !pix.pix_valid;

  // Raster counters; the pixel source is only switched at the frame boundary
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt   <= '0;
      vcnt   <= '0;
      mode_q <= 2'd0;
    end else if (end_line) begin
      hcnt <= '0;
      if (end_frame) begin
        vcnt   <= '0;
        mode_q <= mode;
      end else begin
        vcnt <= vcnt + VW'(1);
      end
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Colour bar index: last bar absorbs any remainder of HDISP/8
  always_comb begin
    bar_idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(x_c) >= i * BAR_W) bar_idx = 3'(i);
    end
  end

  // Pixel colour for the current counter position
  always_comb begin
    rgb_c = 24'h000000;
    if (active) begin
      case (mode_q)
        2'd0:    rgb_c = grid_on ? 24'hFFFFFF : 24'h000000;
        2'd1:    rgb_c = bar_colour(bar_idx);
        2'd2:    rgb_c = solid_rgb;
        default: rgb_c = pix.pix_valid ? pix.pix_data : UNDERFLOW_RGB;
      endcase
    end
  end

  // Registered video outputs, one cycle behind the counters
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      video_hs    <= ~HS_POL;
      video_vs    <= ~VS_POL;
      video_blank <= 1'b0;
      video_rgb   <= 24'h000000;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= hs_sync ? HS_POL : ~HS_POL;
      video_vs    <= vs_sync ? VS_POL : ~VS_POL;
      video_blank <= active;
      video_rgb   <= rgb_c;
      x_pos       <= active ? x_c : '0;
      y_pos       <= active ? y_c : '0;
      frame_start <= active && (x_c == '0) && (y_c == '0);
    end
  end

  // Sticky starvation flag; a new starvation beats a simultaneous clear
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      underflow <= 1'b0;
    end else if (starve) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen against a frame-position reference model.
module tb_vga_pattern_gen;

  localparam int HDISP = 16, VDISP = 8;
  localparam int HFP = 2, HPULSE = 3, HBP = 2;
  localparam int VFP = 1, VPULSE = 2, VBP = 1;
  localparam int GRID_LOG2 = 2;
  localparam int HAS = HFP + HPULSE + HBP;
  localparam int VAS = VFP + VPULSE + VBP;
  localparam int HTOT = HAS + HDISP;
  localparam int VTOT = VAS + VDISP;
  localparam int FRAME = HTOT * VTOT;

  logic        pixel_clk;
  logic        pixel_rst;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        clr_underflow;
  logic        video_clk, video_hs, video_vs, video_blank;
  logic [23:0] video_rgb;
  logic [3:0]  x_pos;
  logic [2:0]  y_pos;
  logic        frame_start, underflow;

  vga_pattern_gen_if pix_if();

  vga_pattern_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0),
    .GRID_LOG2(GRID_LOG2), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode), .solid_rgb(solid_rgb),
    .pix(pix_if), .clr_underflow(clr_underflow), .video_clk(video_clk),
    .video_hs(video_hs), .video_vs(video_vs), .video_blank(video_blank),
    .video_rgb(video_rgb), .x_pos(x_pos), .y_pos(y_pos),
    .frame_start(frame_start), .underflow(underflow)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int n_tests = 0, n_fail = 0;

  // Reference model state: cycles since reset release, latched mode, stream position
  int          t, exp_item, src_cnt;
  logic [1:0]  mq;
  bit          e_hs, e_vs, e_blank, e_fs, e_uf;
  logic [23:0] e_rgb;
  int          e_x, e_y;
  bit          ready_prev, drop_req, rand_solid;
  int          hs_lo, vs_lo, blank_hi, fs_cnt, rdy_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit act_at(input int tt);
    int h, v;
    h = tt % HTOT;
    v = (tt / HTOT) % VTOT;
    return (h >= HAS) && (v >= VAS);
  endfunction

  function automatic logic [23:0] bar_colour(input int x);
    int idx;
    idx = x / (HDISP / 8);
    if (idx > 7) idx = 7;
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected outputs after the clock edge that consumes raster position t
  task automatic model_step();
    int  h, v, g;
    bit  act, valid;
    h     = t % HTOT;
    v     = (t / HTOT) % VTOT;
    g     = 1 << GRID_LOG2;
    act   = act_at(t);
    valid = (pix_if.pix_valid === 1'b1);
    e_blank = act;
    e_x   = act ? h - HAS : 0;
    e_y   = act ? v - VAS : 0;
    e_hs  = !((h >= HFP) && (h < HFP + HPULSE));
    e_vs  = !((v >= VFP) && (v < VFP + VPULSE));
    e_fs  = act && (e_x == 0) && (e_y == 0);
    e_rgb = 24'h000000;
    if (act) begin
      case (mq)
        2'd0: e_rgb = ((e_x % g == g - 1) || (e_y % g == g - 1)) ? 24'hFFFFFF : 24'h000000;
        2'd1: e_rgb = bar_colour(e_x);
        2'd2: e_rgb = solid_rgb;
        default: begin
          if (valid) begin
            e_rgb = 24'(exp_item);
            exp_item++;
          end else begin
            e_rgb = 24'hFF00FF;
          end
        end
      endcase
    end
    if (act && (mq == 2'd3) && !valid) e_uf = 1'b1;
    else if (clr_underflow) e_uf = 1'b0;
    if ((h == HTOT - 1) && (v == VTOT - 1)) mq = mode;
    t++;
  endtask

  task automatic run_cycle();
    bit exp_rdy;
    @(negedge pixel_clk);
    if (ready_prev && pix_if.pix_valid) src_cnt++;
    model_step();
    check("hs", 32'(video_hs), 32'(e_hs));
    check("vs", 32'(video_vs), 32'(e_vs));
    check("blank", 32'(video_blank), 32'(e_blank));
    check("rgb", 32'(video_rgb), 32'(e_rgb));
    check("x_pos", 32'(x_pos), 32'(e_x));
    check("y_pos", 32'(y_pos), 32'(e_y));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("underflow", 32'(underflow), 32'(e_uf));
    if (video_hs == 1'b0) hs_lo++;
    if (video_vs == 1'b0) vs_lo++;
    if (video_blank) blank_hi++;
    if (frame_start) fs_cnt++;
    exp_rdy = (mq == 2'd3) && act_at(t);
    check("pix_ready", 32'(pix_if.pix_ready), 32'(exp_rdy));
    if (pix_if.pix_ready) rdy_cnt++;
    ready_prev = pix_if.pix_ready;
    pix_if.pix_data = 24'(src_cnt);
    if (mq == 2'd3) begin
      pix_if.pix_valid = !(drop_req && exp_rdy);
      if (drop_req && exp_rdy) drop_req = 1'b0;
    end else begin
      pix_if.pix_valid = 1'($urandom_range(0, 1));
    end
    if (rand_solid) solid_rgb = 24'($urandom);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic clear_stats();
    hs_lo = 0; vs_lo = 0; blank_hi = 0; fs_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hs"}, 32'(video_hs), 32'd1);
    check({tag, "_vs"}, 32'(video_vs), 32'd1);
    check({tag, "_blank"}, 32'(video_blank), 32'd0);
    check({tag, "_rgb"}, 32'(video_rgb), 32'd0);
    check({tag, "_x"}, 32'(x_pos), 32'd0);
    check({tag, "_y"}, 32'(y_pos), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_uf"}, 32'(underflow), 32'd0);
    check({tag, "_ready"}, 32'(pix_if.pix_ready), 32'd0);
  endtask

  initial begin
    int k;
    pixel_rst = 1'b1;
    mode = 2'd0;
    solid_rgb = 24'h000000;
    clr_underflow = 1'b0;
    pix_if.pix_data = 24'h000000;
    pix_if.pix_valid = 1'b0;
    drop_req = 1'b0;
    rand_solid = 1'b0;
    repeat (3) @(negedge pixel_clk);
    check_reset("reset");
    pixel_rst = 1'b0;
    t = 0; mq = 2'd0; exp_item = 0; src_cnt = 0; e_uf = 1'b0;
    ready_prev = pix_if.pix_ready;

    // Frames 0-1: grid, with a mid-frame request for bars in frame 1
    clear_stats();
    k = $urandom_range(20, FRAME - 20);
    run_cycles(FRAME + k);
    mode = 2'd1;
    run_cycles(FRAME - k);
    check("hs_low_cycles", 32'(hs_lo), 32'(2 * VTOT * HPULSE));
    check("vs_low_cycles", 32'(vs_lo), 32'(2 * VPULSE * HTOT));
    check("blank_cycles", 32'(blank_hi), 32'(2 * HDISP * VDISP));
    check("frame_starts", 32'(fs_cnt), 32'd2);

    // Frame 2: bars; request grid again mid-frame
    k = $urandom_range(20, FRAME - 20);
    run_cycles(k);
    mode = 2'd0;
    run_cycles(FRAME - k);

    // Frame 3: grid; switch to solid 123456 mid-frame
    k = $urandom_range(20, FRAME - 20);
    run_cycles(k);
    mode = 2'd2;
    solid_rgb = 24'h123456;
    run_cycles(FRAME - k);

    // Frame 4: solid; request external mode, solid colour then varies per cycle
    k = $urandom_range(130, 200);
    run_cycles(k);
    mode = 2'd3;
    rand_solid = 1'b1;
    run_cycles(FRAME - k);
    rand_solid = 1'b0;

    // Frame 5: external stream, always valid
    clear_stats();
    run_cycles(FRAME);
    check("ready_cycles", 32'(rdy_cnt), 32'(HDISP * VDISP));
    check("items_consumed", 32'(src_cnt), 32'(HDISP * VDISP));
    check("frame_starts_ext", 32'(fs_cnt), 32'd1);

    // Frame 6: one starved pixel, then clear the sticky flag
    k = $urandom_range(0, 60);
    run_cycles(k);
    drop_req = 1'b1;
    run_cycles(100);
    check("uf_sticky", 32'(underflow), 32'd1);
    clr_underflow = 1'b1;
    run_cycles(1);
    clr_underflow = 1'b0;
    run_cycles(FRAME - k - 101);

    // Frame 7: starve again, then reset in the middle of an active line
    run_cycles(40);
    drop_req = 1'b1;
    run_cycles(110);
    check("uf_before_rst", 32'(underflow), 32'd1);
    check("blank_before_rst", 32'(video_blank), 32'd1);
    #2;
    pixel_rst = 1'b1;
    #1;
    check_reset("rst_mid");
    repeat (2) @(negedge pixel_clk);
    check_reset("rst_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
